// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port unified memory between the instruction-fetch side
//   (I-side) and the load/store side (D-side). Exactly one memory transaction
//   is in flight at a time. The D-side wins simultaneous requests, but a
//   streak counter limits how many back-to-back D grants can be given while a
//   fetch is waiting, so fetch can never be starved.
//
//   Transaction timeline (one column per cycle):
//     IDLE  : sample i_req/d_req, register the winner's fields onto mem_*
//     ISSUE : mem_req held with stable mem_* until mem_gnt
//     WAIT  : wait for mem_rvalid, capture mem_rdata (0 for stores)
//     RESP  : one-cycle i_rvalid or d_rvalid pulse to the owner, back to IDLE
//
// Parameters
//   STARVE_LIMIT  max consecutive D grants while i_req is pending (>= 1)
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   i_req, i_addr            fetch request and byte address (word-aligned on mem_addr)
//   i_rvalid, i_rdata        fetch completion pulse and instruction word
//   d_req, d_we, d_addr,
//   d_wstrb, d_wdata         load/store request and its fields
//   d_rvalid, d_rdata        load/store completion pulse and load data (0 for stores)
//   mem_req, mem_we, mem_addr,
//   mem_wstrb, mem_wdata     request to the memory port, stable until mem_gnt
//   mem_gnt                  memory accepted the request this cycle
//   mem_rvalid, mem_rdata    memory response
//   busy                     a transaction is in progress
//   owner                    0 = I-side, 1 = D-side; current or last transaction
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_rvalid,
   output logic [31:0] i_rdata,

   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [3:0]  d_wstrb,
   input  logic [31:0] d_wdata,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,

   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,

   output logic        busy,
   output logic        owner
);

   localparam int                  STREAK_W   = $clog2(STARVE_LIMIT + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);
   localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   logic [1:0]          state;
   logic [STREAK_W-1:0] streak;
   logic                grant_d;
   logic                grant_i;
   logic                fetch_starved;

   // A fetch is starved once the D-side has used up its streak while the
   // fetch was pending; the fetch then wins the next arbitration.
   assign fetch_starved = i_req && (streak == STREAK_MAX);

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the block leaves a value unassigned and no latch is inferred.
   always_comb begin
      grant_d = 1'b0;
      grant_i = 1'b0;
      if (d_req && !fetch_starved) begin
         grant_d = 1'b1;
      end else if (i_req) begin
         grant_i = 1'b1;
      end
   end

   assign busy = (state != S_IDLE);

   // NOTE: all sequential state uses non-blocking assignments so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         streak    <= '0;
         owner     <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'h0;
         mem_wstrb <= 4'h0;
         mem_wdata <= 32'h0;
         i_rvalid  <= 1'b0;
         i_rdata   <= 32'h0;
         d_rvalid  <= 1'b0;
         d_rdata   <= 32'h0;
      end else begin
         // Response pulses last exactly one cycle (the RESP cycle).
         i_rvalid <= 1'b0;
         d_rvalid <= 1'b0;

         case (state)
            S_IDLE: begin
               if (grant_d) begin
                  state     <= S_ISSUE;
                  owner     <= 1'b1;
                  mem_req   <= 1'b1;
                  mem_we    <= d_we;
                  mem_addr  <= d_addr;
                  mem_wstrb <= d_we ? d_wstrb : 4'h0;
                  mem_wdata <= d_wdata;
                  // The streak only grows while a fetch is actually waiting;
                  // an uncontested D grant starts the count over.
                  if (i_req) begin
                     streak <= (streak == STREAK_MAX) ? streak : streak + STREAK_ONE;
                  end else begin
                     streak <= '0;
                  end
               end else if (grant_i) begin
                  state     <= S_ISSUE;
                  owner     <= 1'b0;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_addr  <= i_addr & 32'hFFFF_FFFC;
                  mem_wstrb <= 4'h0;
                  mem_wdata <= 32'h0;
                  streak    <= '0;
               end
            end

            S_ISSUE: begin
               // Without a grant every mem_* field simply keeps its value.
               if (mem_gnt) begin
                  state   <= S_WAIT;
                  mem_req <= 1'b0;
               end
            end

            S_WAIT: begin
               if (mem_rvalid) begin
                  state <= S_RESP;
                  if (owner) begin
                     d_rvalid <= 1'b1;
                     d_rdata  <= mem_we ? 32'h0 : mem_rdata;
                  end else begin
                     i_rvalid <= 1'b1;
                     i_rdata  <= mem_rdata;
                  end
               end
            end

            S_RESP: begin
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
